phase_accumulator_sweep: RTL and testbench

Parametrised phase accumulator for the DDS path. It replaces the fixed 8-bit accumulator with these additions:
- configurable accumulator and output widths;
- a handshaked frequency-word load, either immediate or phase-continuous;
- linear frequency sweep;
- output phase offset;
- synchronous phase clear and a wrap pulse.

Its truncated, offset phase output drives the waveform lookup stage.

---
 rtl/phase_accumulator_sweep.sv | 122 ++++++++++++
 tb/tb_phase_accumulator_sweep.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator_sweep.sv
// DDS phase accumulator with a handshaked frequency load (immediate or at the next wrap),
// a linear frequency sweep, an output phase offset, a synchronous clear and a wrap pulse.
module phase_accumulator_sweep #(
   parameter int ACC_W  = 16,
   parameter int FREQ_W = 16,
   parameter int OUT_W  = 8
) (
   input  logic              clk_100kHz,
   input  logic              rst,
   input  logic              en,
   input  logic              phase_clr,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [FREQ_W-1:0] cfg_freq,
   input  logic              cfg_mode,
   input  logic              sweep_en,
   input  logic [FREQ_W-1:0] sweep_step,
   input  logic [FREQ_W-1:0] sweep_stop,
   input  logic [OUT_W-1:0]  phase_off,
   output logic [OUT_W-1:0]  acc_sum,
   output logic              wrap,
   output logic [FREQ_W-1:0] freq_cur,
   output logic              sweep_done
);

   typedef enum logic [1:0] {RUN, PEND, SWEEP, DONE} state_t;

   state_t              state_q;
   logic [ACC_W-1:0]    acc_q;
   logic [OUT_W-1:0]    acc_sum_q;
   logic                wrap_q;
   logic [FREQ_W-1:0]   freq_cur_q;
   logic [FREQ_W-1:0]   shadow_q;

   logic [ACC_W:0]      sum_d;
   logic                carry_d;
   logic [FREQ_W:0]     sweep_nxt_d;
   logic                accept_d;
   logic                wrap_evt_d;

   assign cfg_ready  = (state_q == RUN) & ~sweep_en;
   assign acc_sum    = acc_sum_q;
   assign wrap       = wrap_q;
   assign freq_cur   = freq_cur_q;
   assign sweep_done = (state_q == DONE);

   always_comb begin
      sum_d       = {1'b0, acc_q} + (ACC_W+1)'(freq_cur_q);
      carry_d     = sum_d[ACC_W];
      // One extra bit so a step past the top of the range still compares as >= stop.
      sweep_nxt_d = {1'b0, freq_cur_q} + {1'b0, sweep_step};
      accept_d    = cfg_valid & cfg_ready;
      // A clear suppresses the carry, so it never counts as the wrap a pending load waits for.
      wrap_evt_d  = en & carry_d & ~phase_clr;
   end

   always_ff @(posedge clk_100kHz) begin
      if (rst) begin
         state_q    <= RUN;
         freq_cur_q <= '0;
         shadow_q   <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (accept_d) begin
                  if (cfg_mode) begin
                     shadow_q <= cfg_freq;
                     state_q  <= PEND;
                  end else begin
                     freq_cur_q <= cfg_freq;
                  end
               end else if (sweep_en) begin
                  state_q <= SWEEP;
               end
            end
            PEND: begin
               if (wrap_evt_d) begin
                  freq_cur_q <= shadow_q;
                  state_q    <= RUN;
               end
            end
            SWEEP: begin
               if (!sweep_en) begin
                  state_q <= RUN;
               end else if (en) begin
                  if (sweep_nxt_d >= {1'b0, sweep_stop}) begin
                     freq_cur_q <= sweep_stop;
                     state_q    <= DONE;
                  end else begin
                     freq_cur_q <= sweep_nxt_d[FREQ_W-1:0];
                  end
               end
            end
            DONE: begin
               if (!sweep_en) state_q <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end

   // Accumulator path reads the pre-update freq_cur_q, so a new word takes effect one add later.
   always_ff @(posedge clk_100kHz) begin
      if (rst) begin
         acc_q     <= '0;
         acc_sum_q <= '0;
         wrap_q    <= 1'b0;
      end else if (phase_clr) begin
         acc_q     <= '0;
         acc_sum_q <= phase_off;
         wrap_q    <= 1'b0;
      end else if (en) begin
         acc_q     <= sum_d[ACC_W-1:0];
         acc_sum_q <= sum_d[ACC_W-1 -: OUT_W] + phase_off;
         wrap_q    <= carry_d;
      end else begin
         acc_sum_q <= acc_q[ACC_W-1 -: OUT_W] + phase_off;
         wrap_q    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_phase_accumulator_sweep.sv
// Directed bench for phase_accumulator_sweep (ACC_W=16, FREQ_W=16, OUT_W=8).
module tb_phase_accumulator_sweep;

   logic        clk_100kHz = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        phase_clr = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [15:0] cfg_freq = '0;
   logic        cfg_mode = 1'b0;
   logic        sweep_en = 1'b0;
   logic [15:0] sweep_step = '0;
   logic [15:0] sweep_stop = '0;
   logic [7:0]  phase_off = '0;
   logic [7:0]  acc_sum;
   logic        wrap;
   logic [15:0] freq_cur;
   logic        sweep_done;

   int tests  = 0;
   int failed = 0;

   phase_accumulator_sweep #(.ACC_W(16), .FREQ_W(16), .OUT_W(8)) dut (
      .clk_100kHz (clk_100kHz),
      .rst        (rst),
      .en         (en),
      .phase_clr  (phase_clr),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_freq   (cfg_freq),
      .cfg_mode   (cfg_mode),
      .sweep_en   (sweep_en),
      .sweep_step (sweep_step),
      .sweep_stop (sweep_stop),
      .phase_off  (phase_off),
      .acc_sum    (acc_sum),
      .wrap       (wrap),
      .freq_cur   (freq_cur),
      .sweep_done (sweep_done)
   );

   always #5 clk_100kHz = ~clk_100kHz;

   task automatic tick();
      @(posedge clk_100kHz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [15:0] f, input logic m);
      cfg_valid = 1'b1; cfg_freq = f; cfg_mode = m;
      tick();
      cfg_valid = 1'b0;
   endtask

   logic [7:0] exp_a [4];
   logic [7:0] exp_b [4];

   initial begin
      exp_a = '{8'h40, 8'h80, 8'hC0, 8'h00};
      exp_b = '{8'h50, 8'h90, 8'hD0, 8'h10};

      // Reset state
      tick(); tick();
      rst = 1'b0;
      chk("rst_acc_sum", acc_sum, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_freq", freq_cur, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_done", sweep_done, 0);
      sweep_en = 1'b1; #1;
      chk("ready_masked_by_sweep_en", cfg_ready, 0);
      sweep_en = 1'b0; #1;

      // Immediate load
      load(16'h4000, 1'b0);
      chk("imm_freq", freq_cur, 16'h4000);
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("imm_sum%0d", i), acc_sum, exp_a[i]);
         chk($sformatf("imm_wrap%0d", i), wrap, (i == 3));
      end

      // Offset, then hold with a new offset (acc is 0 here after the wrap)
      phase_off = 8'h10;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("off_sum%0d", i), acc_sum, exp_b[i]);
         chk($sformatf("off_wrap%0d", i), wrap, (i == 3));
      end
      en = 1'b0; phase_off = 8'h20;
      tick();
      chk("hold_sum", acc_sum, 8'h20);
      chk("hold_wrap", wrap, 0);
      tick();
      chk("hold_sum2", acc_sum, 8'h20);

      // Wrap-aligned load from acc=0x4000
      phase_off = 8'h00; en = 1'b1;
      tick();
      chk("pre_pend_sum", acc_sum, 8'h40);
      cfg_valid = 1'b1; cfg_freq = 16'h8000; cfg_mode = 1'b1;
      tick();
      chk("pend_sum0", acc_sum, 8'h80);
      chk("pend_freq0", freq_cur, 16'h4000);
      chk("pend_ready0", cfg_ready, 0);
      cfg_freq = 16'h1234; cfg_mode = 1'b0;
      tick();
      chk("pend_sum1", acc_sum, 8'hC0);
      chk("pend_ready1", cfg_ready, 0);
      chk("pend_freq1", freq_cur, 16'h4000);
      tick();
      cfg_valid = 1'b0;
      chk("pend_sum2", acc_sum, 8'h00);
      chk("pend_wrap2", wrap, 1);
      chk("pend_freq2", freq_cur, 16'h8000);
      chk("pend_ready2", cfg_ready, 1);
      tick();
      chk("post_sum0", acc_sum, 8'h80);
      chk("post_wrap0", wrap, 0);
      tick();
      chk("post_sum1", acc_sum, 8'h00);
      chk("post_wrap1", wrap, 1);

      // Sweep 0x1000 -> 0x2400 in 0x0800 steps
      en = 1'b0;
      load(16'h1000, 1'b0);
      sweep_step = 16'h0800; sweep_stop = 16'h2400; sweep_en = 1'b1; en = 1'b1;
      tick();
      chk("sw_entry_freq", freq_cur, 16'h1000);
      chk("sw_ready", cfg_ready, 0);
      chk("sw_done0", sweep_done, 0);
      tick();
      chk("sw_f1", freq_cur, 16'h1800);
      tick();
      chk("sw_f2", freq_cur, 16'h2000);
      tick();
      chk("sw_f3", freq_cur, 16'h2400);
      chk("sw_done1", sweep_done, 1);
      tick();
      chk("sw_hold_freq", freq_cur, 16'h2400);
      chk("sw_hold_done", sweep_done, 1);
      chk("sw_hold_ready", cfg_ready, 0);
      sweep_en = 1'b0;
      tick();
      chk("sw_exit_done", sweep_done, 0);
      chk("sw_exit_ready", cfg_ready, 1);
      chk("sw_exit_freq", freq_cur, 16'h2400);

      // Saturation: stepping past 0xFFFF must clamp, not wrap
      en = 1'b0;
      load(16'hF000, 1'b0);
      sweep_step = 16'h2000; sweep_stop = 16'hFFFF; sweep_en = 1'b1; en = 1'b1;
      tick();
      chk("sat_entry", freq_cur, 16'hF000);
      tick();
      chk("sat_freq", freq_cur, 16'hFFFF);
      chk("sat_done", sweep_done, 1);
      sweep_en = 1'b0;
      tick();

      // Clear priority over en at acc=0x8000 with freq 0x4000
      en = 1'b0; phase_clr = 1'b1;
      tick();
      phase_clr = 1'b0;
      load(16'h4000, 1'b0);
      en = 1'b1;
      tick(); tick();
      chk("clr_pre_sum", acc_sum, 8'h80);
      phase_off = 8'h33; phase_clr = 1'b1;
      tick();
      chk("clr_sum", acc_sum, 8'h33);
      chk("clr_wrap", wrap, 0);
      chk("clr_ready", cfg_ready, 1);
      chk("clr_freq", freq_cur, 16'h4000);
      phase_clr = 1'b0; en = 1'b0;
      tick();
      chk("clr_acc_zero", acc_sum, 8'h33);

      // Clear while pending is not a wrap
      phase_off = 8'h00;
      load(16'h8000, 1'b1);
      en = 1'b1;
      tick(); tick(); tick();
      chk("pclr_pre_sum", acc_sum, 8'hC0);
      phase_clr = 1'b1;
      tick();
      phase_clr = 1'b0;
      chk("pclr_wrap", wrap, 0);
      chk("pclr_ready", cfg_ready, 0);
      chk("pclr_freq", freq_cur, 16'h4000);
      tick(); tick(); tick(); tick();
      chk("pclr_late_wrap", wrap, 1);
      chk("pclr_late_freq", freq_cur, 16'h8000);

      // Reset mid-sweep
      en = 1'b0;
      load(16'h1000, 1'b0);
      sweep_step = 16'h0800; sweep_stop = 16'h2400; sweep_en = 1'b1; en = 1'b1;
      tick(); tick();
      chk("rs_pre_freq", freq_cur, 16'h1800);
      rst = 1'b1;
      tick();
      chk("rs_sum", acc_sum, 0);
      chk("rs_wrap", wrap, 0);
      chk("rs_freq", freq_cur, 0);
      chk("rs_done", sweep_done, 0);
      chk("rs_ready_sweep_hi", cfg_ready, 0);
      sweep_en = 1'b0; #1;
      chk("rs_ready", cfg_ready, 1);
      rst = 1'b0; en = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
